// File: rtl/led_pattern_gen.sv
// Multi-channel LED driver: OFF / ON / BLINK / PWM per channel. Config writes commit only on a tick boundary.
// Define LED_BREATHE_EN to turn mode 11 into a triangle-ramped PWM ("breathe").
module led_pattern_gen #(
  parameter int NUM_LEDS = 8,
  parameter int TICK_DIV = 1048576,
  parameter int IDX_W    = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [IDX_W-1:0]    cfg_idx,
  input  logic [1:0]          cfg_mode,
  input  logic [2:0]          cfg_rate,
  input  logic [7:0]          cfg_duty,
  output logic                tick,
  output logic [NUM_LEDS-1:0] led
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PRESC_PRE  = PW'(TICK_DIV - 2);

  localparam logic [1:0] MODE_OFF   = 2'b00;
  localparam logic [1:0] MODE_ON    = 2'b01;
  localparam logic [1:0] MODE_BLINK = 2'b10;
  localparam logic [1:0] MODE_PWM   = 2'b11;

  logic [PW-1:0]       presc_q;
  logic [7:0]          phase_q;
  logic [7:0]          pwm_cnt_q;
  logic                pend_q;
  logic [IDX_W-1:0]    sh_idx_q;
  logic [1:0]          sh_mode_q;
  logic [2:0]          sh_rate_q;
  logic [7:0]          sh_duty_q;
  logic                accept;
  logic                commit;
  logic [NUM_LEDS-1:0] led_nxt;

  // tick is registered, so it is raised one cycle early to line up with the last prescaler count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q   <= '0;
      tick      <= 1'b0;
      phase_q   <= '0;
      pwm_cnt_q <= '0;
    end else begin
      presc_q   <= (presc_q == PRESC_LAST) ? '0 : presc_q + PW'(1);
      tick      <= (presc_q == PRESC_PRE);
      pwm_cnt_q <= pwm_cnt_q + 8'd1;
      if (tick) phase_q <= phase_q + 8'd1;
    end
  end

  assign cfg_ready = ~pend_q;
  assign accept    = cfg_valid & cfg_ready;
  // accept and commit are exclusive: a fresh entry cannot commit on the tick it arrived with
  assign commit    = tick & pend_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q    <= 1'b0;
      sh_idx_q  <= '0;
      sh_mode_q <= MODE_OFF;
      sh_rate_q <= '0;
      sh_duty_q <= '0;
    end else if (accept) begin
      pend_q    <= 1'b1;
      sh_idx_q  <= cfg_idx;
      sh_mode_q <= cfg_mode;
      sh_rate_q <= cfg_rate;
      sh_duty_q <= cfg_duty;
    end else if (commit) begin
      pend_q    <= 1'b0;
    end
  end

  for (genvar i = 0; i < NUM_LEDS; i++) begin : gen_ch
    // out-of-range indices match no channel, so their commit is silently dropped
    localparam logic [IDX_W-1:0] CH_IDX = IDX_W'(i);
    logic [1:0] mode_q;
    logic [2:0] rate_q;
    logic [7:0] duty_q;
    logic       sel;

    assign sel = commit && (sh_idx_q == CH_IDX);

`ifdef LED_BREATHE_EN
    logic dir_up_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        mode_q   <= MODE_OFF;
        rate_q   <= '0;
        duty_q   <= '0;
        dir_up_q <= 1'b1;
      end else if (sel) begin
        mode_q   <= sh_mode_q;
        rate_q   <= sh_rate_q;
        duty_q   <= sh_duty_q;
        dir_up_q <= 1'b1;
      end else if (tick && (mode_q == MODE_PWM)) begin
        if (dir_up_q) begin
          if (duty_q == 8'hFF) begin
            dir_up_q <= 1'b0;
            duty_q   <= 8'hFE;
          end else begin
            duty_q   <= duty_q + 8'd1;
          end
        end else if (duty_q == 8'h00) begin
          dir_up_q <= 1'b1;
          duty_q   <= 8'h01;
        end else begin
          duty_q   <= duty_q - 8'd1;
        end
      end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        mode_q <= MODE_OFF;
        rate_q <= '0;
        duty_q <= '0;
      end else if (sel) begin
        mode_q <= sh_mode_q;
        rate_q <= sh_rate_q;
        duty_q <= sh_duty_q;
      end
    end
`endif

    always_comb begin
      led_nxt[i] = 1'b0;
      case (mode_q)
        MODE_OFF:   led_nxt[i] = 1'b0;
        MODE_ON:    led_nxt[i] = 1'b1;
        MODE_BLINK: led_nxt[i] = phase_q[rate_q];
        MODE_PWM:   led_nxt[i] = (pwm_cnt_q < duty_q);
        default:    led_nxt[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) led <= '0;
    else     led <= led_nxt;
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen with TICK_DIV=4, NUM_LEDS=4.
// Cycle n is the clock period starting at the n-th rising edge after reset release.
module tb_led_pattern_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [2:0] cfg_idx;
  logic [1:0] cfg_mode;
  logic [2:0] cfg_rate;
  logic [7:0] cfg_duty;
  logic       tick;
  logic [3:0] led;

  int checks = 0;
  int passed = 0;
  int cyc = 0;

  led_pattern_gen #(.NUM_LEDS(4), .TICK_DIV(4), .IDX_W(3)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_idx(cfg_idx), .cfg_mode(cfg_mode), .cfg_rate(cfg_rate), .cfg_duty(cfg_duty),
    .tick(tick), .led(led)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic goto_cyc(input int n);
    int g;
    g = 0;
    while (cyc < n && g < 2000) begin
      step();
      g++;
    end
  endtask

  task automatic do_reset();
    cfg_valid = 1'b0;
    rst = 1'b1;
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drive_req(input logic [2:0] idx, input logic [1:0] mode,
                           input logic [2:0] rate, input logic [7:0] duty);
    cfg_idx = idx; cfg_mode = mode; cfg_rate = rate; cfg_duty = duty;
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
  endtask

  // Full write: returns one cycle after cfg_ready comes back, when led reflects the new config.
  task automatic configure_ch(input logic [2:0] idx, input logic [1:0] mode,
                              input logic [2:0] rate, input logic [7:0] duty);
    int g;
    g = 0;
    while (!cfg_ready && g < 50) begin step(); g++; end
    drive_req(idx, mode, rate, duty);
    g = 0;
    while (!cfg_ready && g < 50) begin step(); g++; end
    checks++;
    if (cfg_ready !== 1'b1) $display("FAIL handshake_done idx=%0d: cfg_ready=%b expected 1", idx, cfg_ready);
    else passed++;
    step();
  endtask

  task automatic test_reset();
    cfg_valid = 1'b0; cfg_idx = '0; cfg_mode = '0; cfg_rate = '0; cfg_duty = '0;
    rst = 1'b1;
    #1;
    checks++; if (led !== 4'b0000) $display("FAIL reset_led: led=%b expected 0000", led); else passed++;
    checks++; if (cfg_ready !== 1'b1) $display("FAIL reset_ready: cfg_ready=%b expected 1", cfg_ready); else passed++;
    checks++; if (tick !== 1'b0) $display("FAIL reset_tick: tick=%b expected 0", tick); else passed++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      checks++;
      if (tick !== ((c % 4) == 3)) $display("FAIL tick_cycle%0d: tick=%b expected %b", c, tick, ((c % 4) == 3));
      else passed++;
      step();
    end
  endtask

  task automatic test_on();
    do_reset();
    drive_req(3'd1, 2'b01, 3'd0, 8'd0);
    checks++; if (cfg_ready !== 1'b0) $display("FAIL on_ready_c1: cfg_ready=%b expected 0", cfg_ready); else passed++;
    goto_cyc(3);
    checks++; if (cfg_ready !== 1'b0) $display("FAIL on_ready_c3: cfg_ready=%b expected 0", cfg_ready); else passed++;
    checks++; if (led !== 4'b0000) $display("FAIL on_led_c3: led=%b expected 0000", led); else passed++;
    goto_cyc(4);
    checks++; if (cfg_ready !== 1'b1) $display("FAIL on_ready_c4: cfg_ready=%b expected 1", cfg_ready); else passed++;
    checks++; if (led !== 4'b0000) $display("FAIL on_led_c4: led=%b expected 0000", led); else passed++;
    goto_cyc(5);
    checks++; if (led !== 4'b0010) $display("FAIL on_led_c5: led=%b expected 0010", led); else passed++;
  endtask

  task automatic test_tick_coincident();
    do_reset();
    goto_cyc(3);
    drive_req(3'd1, 2'b01, 3'd0, 8'd0);
    checks++; if (cfg_ready !== 1'b0) $display("FAIL coin_ready_c4: cfg_ready=%b expected 0", cfg_ready); else passed++;
    goto_cyc(5);
    checks++; if (led !== 4'b0000) $display("FAIL coin_led_c5: led=%b expected 0000", led); else passed++;
    goto_cyc(7);
    checks++; if (cfg_ready !== 1'b0) $display("FAIL coin_ready_c7: cfg_ready=%b expected 0", cfg_ready); else passed++;
    goto_cyc(8);
    checks++; if (cfg_ready !== 1'b1) $display("FAIL coin_ready_c8: cfg_ready=%b expected 1", cfg_ready); else passed++;
    checks++; if (led !== 4'b0000) $display("FAIL coin_led_c8: led=%b expected 0000", led); else passed++;
    goto_cyc(9);
    checks++; if (led !== 4'b0010) $display("FAIL coin_led_c9: led=%b expected 0010", led); else passed++;
  endtask

  task automatic test_busy_ignored();
    do_reset();
    drive_req(3'd1, 2'b01, 3'd0, 8'd0);
    cfg_idx = 3'd1; cfg_mode = 2'b00; cfg_valid = 1'b1;
    step();
    step();
    cfg_valid = 1'b0;
    goto_cyc(5);
    checks++; if (led !== 4'b0010) $display("FAIL busy_led_c5: led=%b expected 0010", led); else passed++;
    goto_cyc(12);
    checks++; if (led !== 4'b0010) $display("FAIL busy_led_c12: led=%b expected 0010", led); else passed++;
  endtask

  task automatic test_blink();
    logic e;
    do_reset();
    drive_req(3'd0, 2'b10, 3'd1, 8'd0);
    for (int c = 5; c < 45; c++) begin
      goto_cyc(c);
      e = (((c - 1) / 8) % 2) == 1;
      checks++;
      if (led[0] !== e) $display("FAIL blink_c%0d: led0=%b expected %b", c, led[0], e);
      else passed++;
    end
  endtask

  task automatic test_pwm();
    int hi;
    logic [7:0] duties [3];
    int exp_hi [3];
    duties[0] = 8'd64;  exp_hi[0] = 64;
    duties[1] = 8'd0;   exp_hi[1] = 0;
    duties[2] = 8'd255; exp_hi[2] = 255;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      configure_ch(3'd2, 2'b11, 3'd0, duties[k]);
      hi = 0;
      for (int n = 0; n < 256; n++) begin
        if (led[2] === 1'b1) hi++;
        step();
      end
      checks++;
      if (hi !== exp_hi[k]) $display("FAIL pwm_duty%0d: high=%0d expected %0d", duties[k], hi, exp_hi[k]);
      else passed++;
    end
  endtask

  task automatic test_bad_idx();
    int t;
    do_reset();
    configure_ch(3'd0, 2'b01, 3'd0, 8'd0);
    checks++; if (led !== 4'b0001) $display("FAIL badidx_pre: led=%b expected 0001", led); else passed++;
    configure_ch(3'd5, 2'b01, 3'd0, 8'd0);
    t = cyc + 8;
    goto_cyc(t);
    checks++; if (led !== 4'b0001) $display("FAIL badidx_led: led=%b expected 0001", led); else passed++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 0; k < 4; k++) configure_ch(3'(k), 2'b01, 3'd0, 8'd0);
    checks++; if (led !== 4'b1111) $display("FAIL rmid_all_on: led=%b expected 1111", led); else passed++;
    drive_req(3'd0, 2'b01, 3'd0, 8'd0);
    checks++; if (cfg_ready !== 1'b0) $display("FAIL rmid_pending: cfg_ready=%b expected 0", cfg_ready); else passed++;
    #2;
    rst = 1'b1;
    #1;
    checks++; if (led !== 4'b0000) $display("FAIL rmid_led: led=%b expected 0000", led); else passed++;
    checks++; if (cfg_ready !== 1'b1) $display("FAIL rmid_ready: cfg_ready=%b expected 1", cfg_ready); else passed++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    goto_cyc(6);
    checks++; if (led !== 4'b0000) $display("FAIL rmid_nocommit_c6: led=%b expected 0000", led); else passed++;
    goto_cyc(10);
    checks++; if (led !== 4'b0000) $display("FAIL rmid_nocommit_c10: led=%b expected 0000", led); else passed++;
  endtask

`ifdef LED_BREATHE_EN
  task automatic test_breathe();
    do_reset();
    drive_req(3'd3, 2'b11, 3'd0, 8'd254);
    goto_cyc(5);
    checks++; if (dut.gen_ch[3].duty_q !== 8'd254) $display("FAIL breathe_t0: duty=%0d expected 254", dut.gen_ch[3].duty_q); else passed++;
    goto_cyc(9);
    checks++; if (dut.gen_ch[3].duty_q !== 8'd255) $display("FAIL breathe_t1: duty=%0d expected 255", dut.gen_ch[3].duty_q); else passed++;
    goto_cyc(13);
    checks++; if (dut.gen_ch[3].duty_q !== 8'd254) $display("FAIL breathe_t2: duty=%0d expected 254", dut.gen_ch[3].duty_q); else passed++;
    goto_cyc(17);
    checks++; if (dut.gen_ch[3].duty_q !== 8'd253) $display("FAIL breathe_t3: duty=%0d expected 253", dut.gen_ch[3].duty_q); else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_on();
    test_tick_coincident();
    test_busy_ignored();
    test_blink();
    test_pwm();
    test_bad_idx();
    test_reset_mid();
`ifdef LED_BREATHE_EN
    test_breathe();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
